dbp_bht_update: RTL and testbench

DBP_BHT_UPDATE -- requirements
Module: dbp_bht_update

---
 rtl/dbp_pkg.sv | 35 +++
 rtl/dbp_res_fifo.sv | 63 ++++++
 rtl/dbp_bht_update.sv | 184 ++++++++++++++++++
 tb/tb_dbp_bht_update.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbp_pkg.sv
// Shared definitions for the branch-history-table update slice: counter
// encodings, update FSM states, resolution FIFO depth and helper functions.
package dbp_pkg;

    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    localparam int RES_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } upd_state_e;

    // Word index of a fetch/resolve PC; callers truncate to their table width.
    function automatic logic [31:0] pc_index(input logic [31:0] pc);
        return pc >> 32'd2;
    endfunction

    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        if (taken && (cnt != ST)) begin
            nxt = cnt + 2'd1;
        end else if (!taken && (cnt != SNT)) begin
            nxt = cnt - 2'd1;
        end else begin
            nxt = cnt;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/dbp_res_fifo.sv
// In-order resolution FIFO; pushes into a full FIFO and pops from an empty
// one are ignored, so callers may drive the strobes unconditionally.
module dbp_res_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == {CNT_W{1'b0}});
    assign o_count = r_count;
    assign o_data  = r_mem[r_rptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Storage array; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= {PTR_W{1'b0}};
            r_rptr  <= {PTR_W{1'b0}};
            r_count <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dbp_bht_update.sv
// Branch history table front end: one-cycle lookup with write forwarding, and a
// buffered read-modify-write updater for 2-bit saturating counters.
module dbp_bht_update
    import dbp_pkg::*;
#(
    parameter int AWIDTH = 10,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_valid,
    input  logic [31:0]       pc,
    output logic [AWIDTH-1:0] bht_add1,
    input  logic [DWIDTH-1:0] bht_rdata1,
    output logic              pred_valid,
    output logic              pred_taken,
    output logic [1:0]        pred_counter,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [31:0]       res_pc,
    input  logic              res_taken,
    output logic [AWIDTH-1:0] bht_add2,
    input  logic [DWIDTH-1:0] bht_rdata2,
    output logic              bht_wen2,
    output logic [DWIDTH-1:0] bht_wdata2,
    output logic              busy,
    output logic [15:0]       upd_count
);

    localparam int FW    = AWIDTH + 1;
    localparam int CNT_W = $clog2(RES_FIFO_DEPTH + 1);

    upd_state_e        r_state;
    upd_state_e        w_state_nxt;
    logic              r_pred_valid;
    logic              r_fwd;
    logic [1:0]        r_fwd_cnt;
    logic              r_rdy;
    logic [15:0]       r_upd_count;
    logic [FW-1:0]     w_head;
    logic [AWIDTH-1:0] w_head_idx;
    logic              w_head_taken;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    logic              w_push;
    logic              w_pop;
    logic [1:0]        w_new_cnt;
    logic              w_unused_rdata1;

    assign bht_add1        = AWIDTH'(pc_index(pc));
    assign w_unused_rdata1 = ^bht_rdata1[DWIDTH-1:2];

    // Lookup pipeline: remember a same-cycle write to the looked-up entry,
    // because the table read returns the value from before that write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pred_valid <= 1'b0;
            r_fwd        <= 1'b0;
            r_fwd_cnt    <= 2'b00;
        end else begin
            r_pred_valid <= pc_valid;
            r_fwd        <= pc_valid & bht_wen2 & (bht_add1 == bht_add2);
            r_fwd_cnt    <= w_new_cnt;
        end
    end

    // Prediction select between forwarded counter and table data.
    always_comb begin
        pred_counter = 2'b00;
        if (r_pred_valid) begin
            if (r_fwd) begin
                pred_counter = r_fwd_cnt;
            end else begin
                pred_counter = bht_rdata1[1:0];
            end
        end else begin
            pred_counter = 2'b00;
        end
    end

    assign pred_valid = r_pred_valid;
    assign pred_taken = pred_counter[1];

    // Resolution acceptance opens on the first clock edge out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdy <= 1'b0;
        end else begin
            r_rdy <= 1'b1;
        end
    end

    assign res_ready = r_rdy & ~w_full;
    assign w_push    = res_valid & res_ready;
    assign w_pop     = (r_state == S_WR);

    dbp_res_fifo #(
        .WIDTH (FW),
        .DEPTH (RES_FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_res_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  ({AWIDTH'(pc_index(res_pc)), res_taken}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_head_idx   = w_head[FW-1:1];
    assign w_head_taken = w_head[0];
    assign w_new_cnt    = sat_update(bht_rdata2[1:0], w_head_taken);

    // Update FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Update FSM next state; a push during WR keeps the pipeline going.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = S_RD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RD:   w_state_nxt = S_WR;
            S_WR: begin
                if ((w_count > CNT_W'(1)) || w_push) begin
                    w_state_nxt = S_RD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Update FSM outputs: RD reads the head entry, WR writes it back.
    always_comb begin
        bht_add2   = {AWIDTH{1'b0}};
        bht_wen2   = 1'b0;
        bht_wdata2 = {DWIDTH{1'b0}};
        case (r_state)
            S_RD: begin
                bht_add2 = w_head_idx;
            end
            S_WR: begin
                bht_add2   = w_head_idx;
                bht_wen2   = 1'b1;
                bht_wdata2 = {bht_rdata2[DWIDTH-1:2], w_new_cnt};
            end
            default: begin
                bht_add2 = {AWIDTH{1'b0}};
            end
        endcase
    end

    // Completed-write counter, wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_upd_count <= 16'd0;
        end else if (r_state == S_WR) begin
            r_upd_count <= r_upd_count + 16'd1;
        end else begin
            r_upd_count <= r_upd_count;
        end
    end

    assign upd_count = r_upd_count;
    assign busy      = ~w_empty | (r_state != S_IDLE);

endmodule

// File: tb/tb_dbp_bht_update.sv
// Self-checking bench for dbp_bht_update: bench-owned BHT RAM plus a reference
// model of pending resolutions and table contents.
module tb_dbp_bht_update;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_valid;
    logic [31:0] pc;
    logic [9:0]  bht_add1;
    logic [31:0] bht_rdata1;
    logic        pred_valid;
    logic        pred_taken;
    logic [1:0]  pred_counter;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_pc;
    logic        res_taken;
    logic [9:0]  bht_add2;
    logic [31:0] bht_rdata2;
    logic        bht_wen2;
    logic [31:0] bht_wdata2;
    logic        busy;
    logic [15:0] upd_count;

    logic        pre_all;
    logic        pre_en;
    logic [9:0]  pre_a;
    logic [31:0] pre_d;
    logic [31:0] mem [1024];

    // Reference model state.
    logic [31:0] ref_mem [1024];
    int          q_idx[$];
    int          q_tk[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_wr;
    int          stall;
    logic        exp_pv;
    logic [1:0]  exp_cnt;
    logic        prev_wen;
    logic        ready_en;
    logic        last_acc;

    dbp_bht_update #(.AWIDTH(10), .DWIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_valid     (pc_valid),
        .pc           (pc),
        .bht_add1     (bht_add1),
        .bht_rdata1   (bht_rdata1),
        .pred_valid   (pred_valid),
        .pred_taken   (pred_taken),
        .pred_counter (pred_counter),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_pc       (res_pc),
        .res_taken    (res_taken),
        .bht_add2     (bht_add2),
        .bht_rdata2   (bht_rdata2),
        .bht_wen2     (bht_wen2),
        .bht_wdata2   (bht_wdata2),
        .busy         (busy),
        .upd_count    (upd_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int i);
        return 32'(i) * 32'h9E37_79B1;
    endfunction

    // Two-port table with registered reads.
    always @(posedge clk) begin
        bht_rdata1 <= mem[bht_add1];
        bht_rdata2 <= mem[bht_add2];
        if (pre_all) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
        end else if (bht_wen2) begin
            mem[bht_add2] <= bht_wdata2;
        end else if (pre_en) begin
            mem[pre_a] <= pre_d;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        int idx;
        int tk;
        int cnt;
        int ncnt;
        logic [31:0] old;
        logic exp_rdy;
        @(negedge clk);
        last_acc = 1'b0;
        if (reset) begin
            chk("rst_pred_valid", 32'(pred_valid), 32'd0);
            chk("rst_pred_taken", 32'(pred_taken), 32'd0);
            chk("rst_pred_counter", 32'(pred_counter), 32'd0);
            chk("rst_res_ready", 32'(res_ready), 32'd0);
            chk("rst_wen2", 32'(bht_wen2), 32'd0);
            chk("rst_add2", 32'(bht_add2), 32'd0);
            chk("rst_wdata2", bht_wdata2, 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_upd_count", 32'(upd_count), 32'd0);
            q_idx.delete();
            q_tk.delete();
            n_wr = 0;
            stall = 0;
            exp_pv = 1'b0;
            prev_wen = 1'b0;
        end else begin
            chk("pred_valid", 32'(pred_valid), 32'(exp_pv));
            if (exp_pv) begin
                chk("pred_counter", 32'(pred_counter), 32'(exp_cnt));
                chk("pred_taken", 32'(pred_taken), 32'(exp_cnt[1]));
            end
            chk("bht_add1", 32'(bht_add1), (pc / 32'd4) % 32'd1024);
            chk("upd_count", 32'(upd_count), n_wr % 65536);
            chk("busy", 32'(busy), 32'(q_idx.size() != 0));
            exp_rdy = ready_en && (q_idx.size() < 4);
            chk("res_ready", 32'(res_ready), 32'(exp_rdy));
            if (bht_wen2) begin
                chk("wen_spacing", 32'(prev_wen), 32'd0);
                if (q_idx.size() == 0) begin
                    chk("write_without_pending", 32'(bht_wen2), 32'd0);
                end else begin
                    idx = q_idx.pop_front();
                    tk = q_tk.pop_front();
                    old = ref_mem[idx];
                    cnt = int'(old % 32'd4);
                    if (tk != 0) ncnt = (cnt == 3) ? 3 : cnt + 1;
                    else ncnt = (cnt == 0) ? 0 : cnt - 1;
                    chk("wr_addr", 32'(bht_add2), 32'(idx));
                    chk("wr_data", bht_wdata2, old - 32'(cnt) + 32'(ncnt));
                    ref_mem[idx] = old - 32'(cnt) + 32'(ncnt);
                    n_wr++;
                end
                stall = 0;
            end else if (q_idx.size() != 0) begin
                stall++;
                chk("write_latency", 32'(stall <= 2), 32'd1);
            end else begin
                stall = 0;
                chk("idle_add2", 32'(bht_add2), 32'd0);
            end
            if (res_valid && exp_rdy) begin
                q_idx.push_back(int'((res_pc / 32'd4) % 32'd1024));
                q_tk.push_back(int'(res_taken));
                last_acc = 1'b1;
            end
            exp_pv = pc_valid;
            if (pc_valid) exp_cnt = ref_mem[(pc / 32'd4) % 32'd1024][1:0];
            prev_wen = bht_wen2;
        end
        @(posedge clk);
        ready_en = !reset;
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q_idx.size() != 0; i++) tick();
        chk("drain", 32'(q_idx.size()), 32'd0);
        tick();
    endtask

    task automatic preload(input int a, input logic [31:0] d);
        pre_en = 1'b1;
        pre_a = 10'(a);
        pre_d = d;
        tick();
        pre_en = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic resolve_one(input logic [31:0] rpc, input logic tk);
        res_valid = 1'b1;
        res_pc = rpc;
        res_taken = tk;
        tick();
        res_valid = 1'b0;
    endtask

    initial begin
        int acc_n;
        int idx;
        reset = 1'b1;
        pc_valid = 1'b0; pc = 32'd0;
        res_valid = 1'b0; res_pc = 32'd0; res_taken = 1'b0;
        pre_all = 1'b1; pre_en = 1'b0; pre_a = 10'd0; pre_d = 32'd0;
        n_wr = 0; stall = 0; exp_pv = 1'b0; exp_cnt = 2'b00;
        prev_wen = 1'b0; ready_en = 1'b0; last_acc = 1'b0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
        #2;
        tick();
        pre_all = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        tick();

        // Lookup of entry 5 holding weakly-taken.
        preload(5, 32'h0000_0002);
        pc_valid = 1'b1; pc = 32'h14;
        tick();
        pc_valid = 1'b0;
        tick();

        // Saturation at both ends still writes and counts.
        preload(3, 32'hABCD_0003);
        resolve_one(32'hC, 1'b1);
        drain();
        chk("sat_taken_entry", mem[3], 32'hABCD_0003);
        preload(3, 32'h0000_0000);
        resolve_one(32'hC, 1'b0);
        drain();
        chk("sat_nt_entry", mem[3], 32'h0000_0000);

        // Four back-to-back taken resolutions to the same entry.
        preload(7, 32'h0000_0000);
        res_valid = 1'b1; res_pc = 32'h1C; res_taken = 1'b1;
        acc_n = 0;
        for (int i = 0; i < 20 && acc_n < 4; i++) begin
            tick();
            if (last_acc) acc_n++;
        end
        res_valid = 1'b0;
        drain();
        chk("same_idx_entry", mem[7], 32'h0000_0003);

        // Lookup during the write of entry 9 must see the written counter.
        preload(9, 32'h0000_0002);
        resolve_one(32'h24, 1'b1);
        tick();
        tick();
        pc_valid = 1'b1; pc = 32'h24;
        tick();
        pc_valid = 1'b0;
        tick();
        drain();

        // Five resolutions offered back-to-back, each held until accepted.
        acc_n = 0;
        res_valid = 1'b1;
        for (int i = 0; i < 30 && acc_n < 5; i++) begin
            res_pc = 32'(16 + acc_n) * 32'd4;
            res_taken = acc_n[0];
            tick();
            if (last_acc) acc_n++;
        end
        res_valid = 1'b0;
        chk("five_accepted", 32'(acc_n), 32'd5);
        drain();

        // Reset while the update of entry 20 is in its read phase.
        preload(20, 32'h0000_0055);
        resolve_one(32'd80, 1'b1);
        tick();
        chk("rd_phase_addr", 32'(bht_add2), 32'd20);
        chk("rd_phase_wen", 32'(bht_wen2), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("reset_entry_kept", mem[20], 32'h0000_0055);

        // Random traffic over a small index set to provoke collisions and a full FIFO.
        for (int i = 0; i < 400; i++) begin
            idx = $urandom_range(0, 15);
            pc_valid = 1'($urandom_range(0, 1));
            pc = ($urandom() & 32'hFFFF_F000) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
            idx = $urandom_range(0, 15);
            res_valid = ($urandom_range(0, 9) < ((i < 200) ? 5 : 9));
            res_pc = ($urandom() & 32'hFFFF_F000) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
            res_taken = 1'($urandom_range(0, 1));
            tick();
        end
        pc_valid = 1'b0;
        res_valid = 1'b0;
        drain();
        for (int i = 0; i < 16; i++) chk("final_entry", mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
